mem_bus_slave: RTL and testbench
================================

Name: mem_bus_slave

Overview:
Single-port word memory with a request/acknowledge FSM. It sits directly downstream of cpu_top and services the CPU memory bus: Addr, bidirectional Data, we, req_valid and data_valid. It holds instructions and data for both fetch and load/store traffic, which the CPU arbiter has already serialised. Fixed, parameterised access latency models a slow memory, so the fetch stall path and the exe-stage stall path in the core are exercised.

Parameters:
ADDR_WIDTH, 32, width of Addr (byte address).
DATA_WIDTH, 32, width of Data and of each memory word.
MEM_DEPTH, 64, number of words; power of two, at least 2.
LATENCY, 2, cycles from request accept to the data_valid cycle; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (low = reset asserted).
Addr  input  ADDR_WIDTH  byte address from the CPU bus.
Data  inout  DATA_WIDTH  write data from the CPU (we=1); read data driven by this block during its response cycle.
we  input  1  1 = write, 0 = read; sampled with req_valid.
req_valid  input  1  request strobe from the CPU arbiter.
data_valid  output  1  one-cycle response pulse (read data valid / write acknowledge).
busy  output  1  high from the cycle after accept through the response cycle.
addr_err  output  1  pulses together with data_valid when the request was out of range.

Behaviour:
- Addressing: word index = Addr >> 2; Addr[1:0] ignored. In range iff (Addr >> 2) < MEM_DEPTH, computed on the full ADDR_WIDTH value.
- FSM states: IDLE, WAIT, RESP.
- IDLE: when req_valid=1, capture Addr, we and (if we=1) Data into internal registers, and load cnt = LATENCY-1.
  - Go to RESP if LATENCY=1, else go to WAIT.
  - When req_valid=0, stay in IDLE.
- WAIT: cnt decrements by 1 each cycle. When cnt reaches 1, go to RESP on the next edge, so total accept-to-RESP = LATENCY cycles.
- RESP: data_valid=1 for exactly this cycle, then go to IDLE.
  - Read: Data driven with mem[idx] sampled in this cycle.
  - Write: mem[idx] <= captured data on the edge ending RESP.
  - Out-of-range read: drives 0 and sets addr_err=1.
  - Out-of-range write: dropped, addr_err=1.
- Requests are not queued. req_valid, Addr, Data and we are ignored in WAIT and RESP.
- The requester deasserts or changes its request in the cycle after data_valid. Any req_valid=1 seen in IDLE is a new request, so back-to-back requests are accepted with one IDLE cycle between them: minimum period LATENCY+1 cycles.
- Data bus: this block drives Data only when state=RESP and the captured we=0. At all other times Data is high-Z from this block. It never drives while the CPU may be driving a write.
- Ordering: a read following a write to the same word returns the new value, because the write commits before the next accept.
- Outputs data_valid, busy and addr_err are registered or decoded from state only; there is no combinational path from req_valid.
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, data_valid=0, busy=0, addr_err=0, Data high-Z.
  - Memory contents are not reset; they are preloaded by the bench or by $readmemh.
  - Reset during WAIT or RESP abandons the request; a pending write is not committed.
- Deassertion of reset is synchronised by the integrator, not by this block.

Test Plan:
- Read, LATENCY=2: preload mem[3]=0xDEADBEEF; req_valid=1, we=0, Addr=0x0C at cycle 0. Required: data_valid=1 and Data=0xDEADBEEF at cycle 2 only; busy=1 in cycles 1-2; addr_err=0.
- Write then read: write Addr=0x10, Data=0x12345678, then read Addr=0x11 on the first IDLE cycle after the ack. Required: write ack pulse; then read returns 0x12345678 (low address bits ignored).
- Out of range, MEM_DEPTH=64: read Addr=0x100 -> data_valid=1, addr_err=1, Data=0. Write Addr=0x104 -> addr_err=1, and a subsequent read of mem[1] is unchanged.
- Ignored requests: toggle Addr and Data with req_valid=1 during WAIT. Required: the response uses only the originally captured address; exactly one data_valid pulse per accept.
- LATENCY=1: back-to-back reads of 0x0 and 0x4. Required: data_valid in cycles 1 and 3, correct data each time, Data high-Z in cycles 0, 2 and 4.
- Reset mid-write: accept a write to 0x8 (LATENCY=3); drive reset=0 in cycle 1 asynchronously. Required: data_valid, busy and addr_err immediately 0, state IDLE, and mem[2] retains its old value.

Source files
------------

// File: rtl/mem_bus_slave.sv
// Single-port word memory that answers CPU bus requests after a fixed latency.
// One request at a time: IDLE accepts, WAIT counts down, RESP returns data or acknowledges a write.
module mem_bus_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Addr,
    inout  wire  [DATA_WIDTH-1:0] Data,
    input  logic                  we,
    input  logic                  req_valid,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  addr_err
);
    localparam int         IW       = $clog2(MEM_DEPTH);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  we_q, we_d;
    logic                  oor_q, oor_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Range check uses the full word address so aliasing high addresses are rejected.
    assign word_addr = Addr >> 2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        oor_d   = oor_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    idx_d   = word_addr[IW-1:0];
                    we_d    = we;
                    oor_d   = (word_addr >= ADDR_WIDTH'(MEM_DEPTH));
                    cnt_d   = CNT_LOAD;
                    state_d = (CNT_LOAD == 4'd0) ? S_RESP : S_WAIT;
                    if (we) wdata_d = Data;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            wdata_q <= wdata_d;
        end
    end

    // Write commits on the edge leaving RESP; a reset before then leaves state IDLE and drops it.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && we_q && !oor_q) mem[idx_q] <= wdata_q;
    end

    assign rdata      = oor_q ? '0 : mem[idx_q];
    assign Data       = (state_q == S_RESP && !we_q) ? rdata : 'z;
    assign data_valid = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);
    assign addr_err   = (state_q == S_RESP) && oor_q;
endmodule

// File: tb/tb_mem_bus_slave.sv
// Bench for mem_bus_slave: three instances (LATENCY 2, 1, 3) checked every cycle against a
// pending-request model, plus directed transactions with literal expected values.
module tb_mem_bus_slave;
    logic        clk = 1'b0;
    logic [2:0]  rst, rv, w, oe;
    logic [2:0]  dv, bz, ae;
    logic [31:0] a  [3];
    logic [31:0] wd [3];
    wire  [31:0] d0, d1, d2;
    int          lat [3] = '{2, 1, 3};
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign d0 = oe[0] ? wd[0] : 'z;
    assign d1 = oe[1] ? wd[1] : 'z;
    assign d2 = oe[2] ? wd[2] : 'z;

    mem_bus_slave #(.LATENCY(2)) u_l2 (.clk(clk), .reset(rst[0]), .Addr(a[0]), .Data(d0), .we(w[0]),
        .req_valid(rv[0]), .data_valid(dv[0]), .busy(bz[0]), .addr_err(ae[0]));
    mem_bus_slave #(.LATENCY(1)) u_l1 (.clk(clk), .reset(rst[1]), .Addr(a[1]), .Data(d1), .we(w[1]),
        .req_valid(rv[1]), .data_valid(dv[1]), .busy(bz[1]), .addr_err(ae[1]));
    mem_bus_slave #(.LATENCY(3)) u_l3 (.clk(clk), .reset(rst[2]), .Addr(a[2]), .Data(d2), .we(w[2]),
        .req_valid(rv[2]), .data_valid(dv[2]), .busy(bz[2]), .addr_err(ae[2]));

    function automatic logic [31:0] bus(input int k);
        case (k)
            0:       return d0;
            1:       return d1;
            default: return d2;
        endcase
    endfunction

    // A simulator without 4-state nets resolves an undriven bus to 0.
    function automatic bit hiz(input logic [31:0] v);
        return (v === 32'bz) || (v === 32'b0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Model: one outstanding request per instance, aged in cycles since accept.
    bit          pend   [3];
    int          age    [3];
    logic [31:0] m_addr [3];
    logic [31:0] m_data [3];
    bit          m_we   [3];
    logic [31:0] mem_m  [3][64];
    bit          known  [3][64];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst[k]) begin
                pend[k] = 0;
            end else if (pend[k]) begin
                if (age[k] == lat[k]) begin
                    if (m_we[k] && (m_addr[k] >> 2) < 64) begin
                        mem_m[k][m_addr[k] >> 2] = m_data[k];
                        known[k][m_addr[k] >> 2] = 1;
                    end
                    pend[k] = 0;
                end else begin
                    age[k]++;
                end
            end else if (rv[k]) begin
                pend[k]   = 1;
                age[k]    = 1;
                m_addr[k] = a[k];
                m_we[k]   = w[k];
                m_data[k] = wd[k];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit          e_dv, e_bz, e_ae, oor;
            logic [31:0] q;
            oor  = (m_addr[k] >> 2) >= 64;
            e_bz = rst[k] && pend[k];
            e_dv = e_bz && age[k] == lat[k];
            e_ae = e_dv && oor;
            q    = bus(k);
            chk($sformatf("cmp_dv%0d", k), 32'(dv[k]), 32'(e_dv));
            chk($sformatf("cmp_busy%0d", k), 32'(bz[k]), 32'(e_bz));
            chk($sformatf("cmp_aerr%0d", k), 32'(ae[k]), 32'(e_ae));
            if (e_dv && !m_we[k]) begin
                if (oor) chk($sformatf("cmp_oordata%0d", k), q, 32'h0);
                else if (known[k][m_addr[k] >> 2])
                    chk($sformatf("cmp_rdata%0d", k), q, mem_m[k][m_addr[k] >> 2]);
            end else if (!oe[k]) begin
                chk($sformatf("cmp_hiz%0d", k), 32'(hiz(q)), 32'd1);
            end
        end
    end

    // Entered just after a rising edge with the instance idle; returns on its next idle cycle.
    task automatic do_txn(input int k, input logic [31:0] addr, input logic wr, input logic [31:0] data,
                          input bit junk, output int np, output logic [31:0] rd, output logic aerr);
        rv[k] = 1; w[k] = wr; a[k] = addr; wd[k] = data; oe[k] = wr;
        np = 0; rd = 0; aerr = 0;
        for (int i = 0; i <= lat[k]; i++) begin
            @(negedge clk);
            chk($sformatf("txn%0d_dv_cycle%0d", k, i), 32'(dv[k]), 32'(i == lat[k]));
            if (dv[k]) begin np++; rd = bus(k); aerr = ae[k]; end
            @(posedge clk); #1;
            if (junk && i + 1 < lat[k]) begin
                rv[k] = 1; a[k] = addr ^ 32'h1C; wd[k] = ~data; oe[k] = 1;
            end else begin
                rv[k] = 0; oe[k] = 0;
            end
        end
    endtask

    initial begin
        int          np;
        logic [31:0] rd;
        logic        er;
        rst = 3'b000; rv = '0; w = '0; oe = '0;
        for (int k = 0; k < 3; k++) begin a[k] = '0; wd[k] = '0; end
        @(negedge clk);
        chk("reset_outputs", 32'({dv, bz, ae}), 32'd0);
        chk("reset_hiz", 32'(hiz(d0)), 32'd1);
        @(posedge clk); #1;
        rst = 3'b111;

        do_txn(0, 32'h0C, 1, 32'hDEADBEEF, 0, np, rd, er);
        do_txn(0, 32'h04, 1, 32'h11111111, 0, np, rd, er);
        do_txn(1, 32'h00, 1, 32'hA0A00001, 0, np, rd, er);
        do_txn(1, 32'h04, 1, 32'hB0B00002, 0, np, rd, er);
        do_txn(2, 32'h08, 1, 32'hCAFEF00D, 0, np, rd, er);

        // LATENCY 2 read, cycle by cycle
        rv[0] = 1; w[0] = 0; a[0] = 32'h0C;
        @(negedge clk);
        chk("rd_c0_dv", 32'(dv[0]), 32'd0);
        chk("rd_c0_busy", 32'(bz[0]), 32'd0);
        @(posedge clk); #1; rv[0] = 0;
        @(negedge clk);
        chk("rd_c1_dv", 32'(dv[0]), 32'd0);
        chk("rd_c1_busy", 32'(bz[0]), 32'd1);
        @(negedge clk);
        chk("rd_c2_dv", 32'(dv[0]), 32'd1);
        chk("rd_c2_busy", 32'(bz[0]), 32'd1);
        chk("rd_c2_aerr", 32'(ae[0]), 32'd0);
        chk("rd_c2_data", d0, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_c3_idle", 32'({dv[0], bz[0]}), 32'd0);
        @(posedge clk); #1;

        do_txn(0, 32'h10, 1, 32'h12345678, 0, np, rd, er);
        chk("wr_ack_pulses", 32'(np), 32'd1);
        chk("model_mem4", mem_m[0][4], 32'h12345678);
        do_txn(0, 32'h11, 0, 32'h0, 0, np, rd, er);
        chk("rd_after_wr", rd, 32'h12345678);

        do_txn(0, 32'h100, 0, 32'h0, 0, np, rd, er);
        chk("oor_rd_pulses", 32'(np), 32'd1);
        chk("oor_rd_aerr", 32'(er), 32'd1);
        chk("oor_rd_data", rd, 32'h0);
        do_txn(0, 32'h104, 1, 32'hFFFFFFFF, 0, np, rd, er);
        chk("oor_wr_aerr", 32'(er), 32'd1);
        do_txn(0, 32'h04, 0, 32'h0, 0, np, rd, er);
        chk("oor_wr_dropped", rd, 32'h11111111);

        do_txn(0, 32'h0C, 0, 32'h0, 1, np, rd, er);
        chk("ignored_pulses", 32'(np), 32'd1);
        chk("ignored_data", rd, 32'hDEADBEEF);

        do_txn(1, 32'h00, 0, 32'h0, 0, np, rd, er);
        chk("l1_rd0", rd, 32'hA0A00001);
        do_txn(1, 32'h04, 0, 32'h0, 0, np, rd, er);
        chk("l1_rd1", rd, 32'hB0B00002);
        @(negedge clk);
        chk("l1_c4_hiz", 32'(hiz(d1)), 32'd1);
        chk("l1_c4_dv", 32'(dv[1]), 32'd0);
        @(posedge clk); #1;

        // Reset asserted mid-cycle while a LATENCY 3 write waits
        rv[2] = 1; w[2] = 1; a[2] = 32'h08; wd[2] = 32'hBAD0BAD0; oe[2] = 1;
        @(posedge clk); #1; rv[2] = 0; oe[2] = 0;
        #2 rst[2] = 0;
        #1;
        chk("rst_mid_outputs", 32'({dv[2], bz[2], ae[2]}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1; rst[2] = 1;
        do_txn(2, 32'h08, 0, 32'h0, 0, np, rd, er);
        chk("rst_mid_mem_kept", rd, 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
